// File: rtl/seq_updown_modn.sv
// ============================================================================
// seq_updown_modn : modulo-MOD up/down state counter with match decode,
//                   synchronous load, load-error flag and wrap-event pulses.
// Rev 1.0
// ============================================================================
`default_nettype none

module seq_updown_modn #(
  parameter int MOD      = 4,
  parameter int W        = $clog2(MOD),
  parameter int MATCH    = MOD - 1,
  parameter bit WRAP_REG = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         A,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] cnt,
  output logic         Y,
  output logic         wrap_up,
  output logic         wrap_dn,
  output logic         load_err
);

  localparam logic [W:0]   C_MOD   = (W+1)'(MOD);
  localparam logic [W-1:0] C_TOP   = W'(MOD - 1);
  localparam logic [W-1:0] C_MATCH = W'(MATCH);
  localparam logic [W-1:0] C_ONE   = W'(1);

  logic [W-1:0] cnt_q, cnt_d;
  logic         load_err_q;
  logic         w_load_ok, w_oor, w_at_top, w_at_zero;
  logic         w_wrap_up_evt, w_wrap_dn_evt;

  // One extra bit so MOD itself is representable when MOD == 2**W.
  assign w_load_ok = ({1'b0, load_val} < C_MOD);
  assign w_oor     = ({1'b0, cnt_q} >= C_MOD);
  assign w_at_top  = (cnt_q == C_TOP);
  assign w_at_zero = (cnt_q == '0);

  assign w_wrap_up_evt = en & ~load & ~A & w_at_top;
  assign w_wrap_dn_evt = en & ~load &  A & w_at_zero;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      if (w_load_ok) cnt_d = load_val;
    end else if (w_oor) begin
      cnt_d = '0;
    end else if (en) begin
      if (A) cnt_d = w_at_zero ? C_TOP : (cnt_q - C_ONE);
      else   cnt_d = w_at_top  ? '0    : (cnt_q + C_ONE);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      load_err_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      load_err_q <= load & ~w_load_ok;
    end
  end

  generate
    if (WRAP_REG) begin : g_wrap_reg
      logic wrap_up_q, wrap_dn_q;
      always_ff @(posedge clk) begin
        if (rst) begin
          wrap_up_q <= 1'b0;
          wrap_dn_q <= 1'b0;
        end else begin
          wrap_up_q <= w_wrap_up_evt;
          wrap_dn_q <= w_wrap_dn_evt;
        end
      end
      assign wrap_up = wrap_up_q;
      assign wrap_dn = wrap_dn_q;
    end else begin : g_wrap_comb
      // Flags the wrap that the coming edge will perform.
      assign wrap_up = w_wrap_up_evt;
      assign wrap_dn = w_wrap_dn_evt;
    end
  endgenerate

  assign cnt      = cnt_q;
  assign Y        = (cnt_q == C_MATCH);
  assign load_err = load_err_q;

endmodule

`default_nettype wire

// File: tb/tb_seq_updown_modn.sv
// ============================================================================
// tb_seq_updown_modn : self-checking bench for seq_updown_modn (three configs).
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_seq_updown_modn;

  logic       clk = 1'b0;
  logic       rst = 1'b0, en = 1'b0, a_in = 1'b0, load = 1'b0;
  logic [7:0] lv  = 8'd0;

  logic [1:0] c0; logic y0, wu0, wd0, er0;
  logic [2:0] c1; logic y1, wu1, wd1, er1;
  logic [0:0] c2; logic y2, wu2, wd2, er2;

  int total = 0;
  int bad   = 0;

  // Instance configurations: {MOD, W, MATCH, WRAP_REG}
  int MODS[3]  = '{4, 5, 2};
  int WIDS[3]  = '{2, 3, 1};
  int MATS[3]  = '{3, 2, 0};
  int WREG[3]  = '{1, 1, 0};

  // Reference model state
  int mc[3];
  int mwu[3], mwd[3], merr[3];

  always #5 clk = ~clk;

  seq_updown_modn #(.MOD(4), .MATCH(3), .WRAP_REG(1'b1)) u_d0 (
    .clk(clk), .rst(rst), .en(en), .A(a_in), .load(load), .load_val(lv[1:0]),
    .cnt(c0), .Y(y0), .wrap_up(wu0), .wrap_dn(wd0), .load_err(er0));

  seq_updown_modn #(.MOD(5), .MATCH(2), .WRAP_REG(1'b1)) u_d1 (
    .clk(clk), .rst(rst), .en(en), .A(a_in), .load(load), .load_val(lv[2:0]),
    .cnt(c1), .Y(y1), .wrap_up(wu1), .wrap_dn(wd1), .load_err(er1));

  seq_updown_modn #(.MOD(2), .MATCH(0), .WRAP_REG(1'b0)) u_d2 (
    .clk(clk), .rst(rst), .en(en), .A(a_in), .load(load), .load_val(lv[0:0]),
    .cnt(c2), .Y(y2), .wrap_up(wu2), .wrap_dn(wd2), .load_err(er2));

  function automatic int dcnt(input int i);
    case (i) 0: return int'(c0); 1: return int'(c1); default: return int'(c2); endcase
  endfunction
  function automatic int dy(input int i);
    case (i) 0: return int'(y0); 1: return int'(y1); default: return int'(y2); endcase
  endfunction
  function automatic int dwu(input int i);
    case (i) 0: return int'(wu0); 1: return int'(wu1); default: return int'(wu2); endcase
  endfunction
  function automatic int dwd(input int i);
    case (i) 0: return int'(wd0); 1: return int'(wd1); default: return int'(wd2); endcase
  endfunction
  function automatic int derr(input int i);
    case (i) 0: return int'(er0); 1: return int'(er1); default: return int'(er2); endcase
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: counter value as an integer in [0, MOD), modulo arithmetic.
  task automatic model_step(input int i, input logic r, e, d, l, input logic [7:0] v);
    int m, val;
    m   = MODS[i];
    val = int'(v) % (1 << WIDS[i]);
    mwu[i] = 0; mwd[i] = 0; merr[i] = 0;
    if (r) begin
      mc[i] = 0;
    end else if (l) begin
      if (val < m) mc[i] = val;
      else         merr[i] = 1;
    end else if (e) begin
      if (!d) begin
        mwu[i] = (mc[i] + 1 == m) ? 1 : 0;
        mc[i]  = (mc[i] + 1) % m;
      end else begin
        mwd[i] = (mc[i] == 0) ? 1 : 0;
        mc[i]  = (mc[i] + m - 1) % m;
      end
    end
  endtask

  // One clock: drive, check combinational wrap flags, clock, check state.
  task automatic cyc(input logic r, e, d, l, input logic [7:0] v);
    rst = r; en = e; a_in = d; load = l; lv = v;
    #1;
    for (int i = 0; i < 3; i++) begin
      if (WREG[i] == 0) begin
        chk($sformatf("d%0d_wrap_up_comb", i), dwu(i),
            (e && !l && !d && mc[i] == MODS[i] - 1) ? 1 : 0);
        chk($sformatf("d%0d_wrap_dn_comb", i), dwd(i),
            (e && !l && d && mc[i] == 0) ? 1 : 0);
      end
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      model_step(i, r, e, d, l, v);
      chk($sformatf("d%0d_cnt", i), dcnt(i), mc[i]);
      chk($sformatf("d%0d_Y", i), dy(i), (mc[i] == MATS[i]) ? 1 : 0);
      chk($sformatf("d%0d_load_err", i), derr(i), merr[i]);
      if (WREG[i] != 0) begin
        chk($sformatf("d%0d_wrap_up", i), dwu(i), mwu[i]);
        chk($sformatf("d%0d_wrap_dn", i), dwd(i), mwd[i]);
      end
    end
  endtask

  typedef struct {
    logic       r, e, d, l;
    logic [7:0] v;
    int         cnt, y, wu, wd, err;
  } vec_t;

  vec_t tbl[13];
  int   held, wraps;
  int   exp5[7];

  initial begin
    for (int i = 0; i < 3; i++) begin
      mc[i] = 0; mwu[i] = 0; mwd[i] = 0; merr[i] = 0;
    end

    // Legacy MOD=4 / MATCH=3 behaviour, registered wrap flags.
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 0, 0, 0, 0, 0};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 1, 0, 0, 0, 0};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 2, 0, 0, 0, 0};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 3, 1, 0, 0, 0};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 0, 0, 1, 0, 0};
    tbl[5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 3, 1, 0, 1, 0};
    tbl[6]  = '{1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 2, 0, 0, 0, 0};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b1, 8'd1, 1, 0, 0, 0, 0};
    tbl[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 1, 0, 0, 0, 0};
    tbl[9]  = '{1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 0, 0, 0, 0, 0};
    tbl[10] = '{1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 3, 1, 0, 1, 0};
    tbl[11] = '{1'b1, 1'b1, 1'b0, 1'b1, 8'd2, 0, 0, 0, 0, 0};
    tbl[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 1, 0, 0, 0, 0};

    exp5 = '{1, 2, 3, 4, 0, 1, 2};

    @(posedge clk);
    #1;

    foreach (tbl[k]) begin
      cyc(tbl[k].r, tbl[k].e, tbl[k].d, tbl[k].l, tbl[k].v);
      chk($sformatf("tbl%0d_cnt", k),  int'(c0),  tbl[k].cnt);
      chk($sformatf("tbl%0d_Y", k),    int'(y0),  tbl[k].y);
      chk($sformatf("tbl%0d_wup", k),  int'(wu0), tbl[k].wu);
      chk($sformatf("tbl%0d_wdn", k),  int'(wd0), tbl[k].wd);
      chk($sformatf("tbl%0d_lerr", k), int'(er0), tbl[k].err);
    end

    // Non-power-of-two count, MOD=5 / MATCH=2.
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
    chk("mod2_reset_Y", int'(y2), 1);
    wraps = 0;
    for (int k = 0; k < 7; k++) begin
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
      chk($sformatf("m5_cnt%0d", k), int'(c1), exp5[k]);
      chk($sformatf("m5_Y%0d", k), int'(y1), (exp5[k] == 2) ? 1 : 0);
      wraps += int'(wu1);
    end
    chk("m5_wrap_count", wraps, 1);

    // Load, out-of-range load, load against a concurrent step.
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 8'd3);
    chk("m5_load_cnt", int'(c1), 3);
    chk("m5_load_noerr", int'(er1), 0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 8'd6);
    chk("m5_badload_cnt", int'(c1), 3);
    chk("m5_badload_err", int'(er1), 1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    chk("m5_err_oneshot", int'(er1), 0);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 8'd0);
    chk("m5_load_wins", int'(c1), 0);

    // Enable low: everything holds regardless of direction.
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
    held = int'(c1);
    for (int k = 0; k < 10; k++) begin
      cyc(1'b0, 1'b0, k[0], 1'b0, 8'd0);
      chk($sformatf("hold_cnt%0d", k), int'(c1), held);
      chk($sformatf("hold_nopulse%0d", k), int'(wu1 | wd1), 0);
    end
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
    chk("hold_resume", int'(c1), (held + 1) % 5);

    // Randomised traffic against the model.
    for (int k = 0; k < 400; k++) begin
      cyc(($urandom_range(39) == 0), ($urandom_range(3) != 0), 1'($urandom),
          ($urandom_range(5) == 0), 8'($urandom_range(7)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
